// File: rtl/game_pkg.sv
// Shared game definitions: turn-countdown state encoding and default sizing.
// TC_WARN_SECS exists only when TURN_CD_WARN_EN is defined.
package game_pkg;

    localparam int unsigned TC_CNT_W        = 4;
    localparam int unsigned TC_DEFAULT_SECS = 10;
`ifdef TURN_CD_WARN_EN
    localparam int unsigned TC_WARN_SECS    = 3;
`endif

    localparam int unsigned TC_STATE_W = 3;

    localparam logic [TC_STATE_W-1:0] TC_IDLE    = 3'd0;
    localparam logic [TC_STATE_W-1:0] TC_LOAD    = 3'd1;
    localparam logic [TC_STATE_W-1:0] TC_RUN     = 3'd2;
    localparam logic [TC_STATE_W-1:0] TC_DONE    = 3'd3;
    localparam logic [TC_STATE_W-1:0] TC_EXPIRED = 3'd4;

    typedef enum logic [TC_STATE_W-1:0] {
        ST_IDLE    = TC_IDLE,
        ST_LOAD    = TC_LOAD,
        ST_RUN     = TC_RUN,
        ST_DONE    = TC_DONE,
        ST_EXPIRED = TC_EXPIRED
    } tc_state_e;

endpackage

// File: rtl/turn_countdown.sv
// Per-turn seconds countdown driving the external 1 s timer's run input.
// Optional TURN_CD_WARN_EN adds a registered low-time warning level on Warn.
module turn_countdown
    import game_pkg::*;
#(
    parameter int unsigned CNT_W        = TC_CNT_W,
    parameter int unsigned DEFAULT_SECS = TC_DEFAULT_SECS
`ifdef TURN_CD_WARN_EN
    , parameter int unsigned WARN_SECS  = TC_WARN_SECS
`endif
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             TurnStart,
    input  logic [CNT_W-1:0] Seconds,
    input  logic             PlayerDone,
    input  logic             Tick1s,
    output logic             TimerRun,
    output logic [CNT_W-1:0] Remaining,
    output logic [CNT_W-1:0] Elapsed,
    output logic             DoneValid,
    output logic             Timeout,
    output logic             Warn
);

    tc_state_e        state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [CNT_W-1:0] loaded_q, loaded_d;
    logic             done_valid_q, done_valid_d;
    logic             timer_run_q, timer_run_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] start_secs_c;

    // Seconds is captured at the TurnStart edge; zero selects the default length.
    assign start_secs_c = (Seconds == '0) ? CNT_W'(DEFAULT_SECS) : Seconds;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            elapsed_q    <= '0;
            loaded_q     <= '0;
            done_valid_q <= 1'b0;
            timer_run_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            elapsed_q    <= elapsed_d;
            loaded_q     <= loaded_d;
            done_valid_q <= done_valid_d;
            timer_run_q  <= timer_run_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        elapsed_d    = elapsed_q;
        loaded_d     = loaded_q;
        done_valid_d = done_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (TurnStart) begin
                    state_d  = ST_LOAD;
                    loaded_d = start_secs_c;
                end
            end
            ST_LOAD: begin
                remaining_d  = loaded_q;
                done_valid_d = 1'b0;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                // Restart beats player completion, which beats the final tick.
                if (TurnStart) begin
                    state_d  = ST_LOAD;
                    loaded_d = start_secs_c;
                end else if (PlayerDone) begin
                    state_d      = ST_DONE;
                    elapsed_d    = loaded_q - remaining_q;
                    done_valid_d = 1'b1;
                end else if (Tick1s) begin
                    if (remaining_q > CNT_W'(1)) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_EXPIRED;
                    end
                end
            end
            ST_DONE: begin
                if (TurnStart) begin
                    state_d  = ST_LOAD;
                    loaded_d = start_secs_c;
                end
            end
            ST_EXPIRED: begin
                remaining_d = '0;
                if (TurnStart) begin
                    state_d  = ST_LOAD;
                    loaded_d = start_secs_c;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        timer_run_d = (state_d == ST_RUN);
        timeout_d   = (state_d == ST_EXPIRED);
    end

    assign TimerRun  = timer_run_q;
    assign Remaining = remaining_q;
    assign Elapsed   = elapsed_q;
    assign DoneValid = done_valid_q;
    assign Timeout   = timeout_q;

`ifdef TURN_CD_WARN_EN
    logic warn_q, warn_d;

    always_comb begin
        warn_d = (state_d == ST_RUN) && (remaining_d != '0)
                 && (remaining_d <= CNT_W'(WARN_SECS));
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign Warn = warn_q;
`else
    assign Warn = 1'b0;
`endif

endmodule
